// File: rtl/aes_pipe_ctrl_if.sv
// Handshake and control bundle between the AES round pipeline controller
// and its environment.
//
//  in_valid / in_ready    upstream block handshake (in_fire = both high)
//  out_valid / out_ready  downstream block handshake (out_fire = both high)
//  stage_en               per-stage load enable for the external pipeline registers
//  stage_valid            per-stage "holds a live block" flags
//  key_req / key_load     round-key reload request (level) and load strobe (pulse)
//  busy                   any live block, or controller not idle
//  occupancy              number of live blocks in the pipeline
//  blk_count              number of completed blocks, wrapping
//
// The master modport is the environment (drives requests and out_ready).
// The slave modport is the controller.
interface aes_pipe_ctrl_if #(
   parameter int NUM_STAGES = 10,
   parameter int CNT_W      = 16
);
   localparam int OCC_W = $clog2(NUM_STAGES + 1);

   logic                  in_valid;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [NUM_STAGES-1:0] stage_en;
   logic [NUM_STAGES-1:0] stage_valid;
   logic                  key_req;
   logic                  key_load;
   logic                  busy;
   logic [OCC_W-1:0]      occupancy;
   logic [CNT_W-1:0]      blk_count;

   modport master (
      output in_valid, out_ready, key_req,
      input  in_ready, out_valid, stage_en, stage_valid, key_load, busy,
             occupancy, blk_count
   );

   modport slave (
      input  in_valid, out_ready, key_req,
      output in_ready, out_valid, stage_en, stage_valid, key_load, busy,
             occupancy, blk_count
   );
endinterface

// File: rtl/aes_pipe_ctrl.sv
// Control plane for an unrolled AES round pipeline of NUM_STAGES register
// stages. The 128-bit datapath registers live outside this block; here we
// only decide when each of them loads.
//
// Provides elastic valid/ready flow control with full back-pressure and
// bubble compression, and sequences round-key reloads:
// stop intake, drain in-flight blocks, pulse key_load, resume.
//
// Ports:
//  clk    rising-edge system clock
//  reset  synchronous, active-high; discards all in-flight blocks
//  bus    aes_pipe_ctrl_if.slave handshake/control bundle
module aes_pipe_ctrl #(
   parameter int NUM_STAGES = 10,
   parameter int CNT_W      = 16
) (
   input logic            clk,
   input logic            reset,
   aes_pipe_ctrl_if.slave bus
);
   localparam int OCC_W = $clog2(NUM_STAGES + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUN     = 2'd1;
   localparam logic [1:0] DRAIN   = 2'd2;
   localparam logic [1:0] KEYLOAD = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [NUM_STAGES-1:0] valid_q, valid_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic [NUM_STAGES-1:0] space;
   logic [NUM_STAGES-1:0] adv;
   logic [NUM_STAGES-1:0] stageEn;
   logic                  inReady;
   logic                  inFire;
   logic                  outFire;
   logic [OCC_W-1:0]      occ;

   // Elastic flow control. A stage has room when it is empty or its block
   // moves on this cycle; that is true exactly when there is a hole somewhere
   // at or downstream of it, or the output is being consumed. Accumulating
   // that "hole" flag from the output end keeps the ready ripple free of any
   // feedback through the enable vector.
   always_comb begin : flow
      logic hole;
      space   = '0;
      adv     = '0;
      stageEn = '0;
      hole    = bus.out_ready;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         hole     = hole | ~valid_q[i];
         space[i] = hole;
      end
      adv[NUM_STAGES-1] = valid_q[NUM_STAGES-1] & bus.out_ready;
      for (int i = 0; i < NUM_STAGES - 1; i++) begin
         adv[i] = valid_q[i] & space[i+1];
      end
      inReady = ((state_q == IDLE) || (state_q == RUN)) & space[0] & ~reset;
      inFire  = bus.in_valid & inReady;
      stageEn[0] = inFire;
      for (int i = 1; i < NUM_STAGES; i++) begin
         stageEn[i] = valid_q[i-1] & space[i] & ~reset;
      end
      outFire = adv[NUM_STAGES-1];
      valid_d = stageEn | (valid_q & ~adv);
   end

   // Occupancy is a plain popcount of the live-stage flags.
   always_comb begin
      occ = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         occ = occ + OCC_W'(valid_q[i]);
      end
   end

   // Key-reload sequencer. A key request from IDLE or RUN wins over the
   // normal IDLE/RUN bookkeeping; a block firing in that same cycle is still
   // taken and simply drains with the rest. DRAIN waits for a cycle in which
   // no stage is live, and KEYLOAD lasts one cycle before intake resumes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.key_req) begin
               state_d = DRAIN;
            end else if (inFire) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.key_req) begin
               state_d = DRAIN;
            end else if (valid_d == '0) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (valid_q == '0) begin
               state_d = KEYLOAD;
            end
         end
         KEYLOAD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Completed-block counter; wraps naturally at its width.
   always_comb begin
      count_d = count_q + CNT_W'(outFire);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         valid_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign bus.in_ready    = inReady;
   assign bus.out_valid   = valid_q[NUM_STAGES-1];
   assign bus.stage_en    = stageEn;
   assign bus.stage_valid = valid_q;
   assign bus.key_load    = (state_q == KEYLOAD);
   assign bus.busy        = (|valid_q) | (state_q != IDLE);
   assign bus.occupancy   = occ;
   assign bus.blk_count   = count_q;
endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// Self-checking bench for aes_pipe_ctrl. A reference model tracks in-flight
// blocks as an ordered list of (data, stage position) and moves them forward
// each cycle as far as the block ahead allows. A shadow 128-bit register chain
// driven by the DUT stage enables carries real data so ordering is checked
// end to end. A second DUT with a 4-bit counter shares all inputs.
module tb_aes_pipe_ctrl;
   localparam int N = 10;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_KEY   = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] inData;
   logic [127:0] pipe [N];

   int compared   = 0;
   int mismatched = 0;

   logic [127:0] mData [$];
   int           mPos  [$];
   int           mMode;
   int           mCount;
   logic [127:0] expQ  [$];
   logic [127:0] obsQ  [$];

   aes_pipe_ctrl_if #(.NUM_STAGES(N), .CNT_W(16)) bus ();
   aes_pipe_ctrl_if #(.NUM_STAGES(N), .CNT_W(4))  wbus ();

   aes_pipe_ctrl #(.NUM_STAGES(N), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   aes_pipe_ctrl #(.NUM_STAGES(N), .CNT_W(4)) dutWrap (
      .clk   (clk),
      .reset (rst),
      .bus   (wbus)
   );

   assign wbus.in_valid  = bus.in_valid;
   assign wbus.out_ready = bus.out_ready;
   assign wbus.key_req   = bus.key_req;

   always #5 clk = ~clk;

   // Shadow datapath and output capture.
   always @(posedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         obsQ.push_back(pipe[N-1]);
      end
      if (bus.stage_en[0]) pipe[0] <= inData;
      for (int i = 1; i < N; i++) begin
         if (bus.stage_en[i]) pipe[i] <= pipe[i-1];
      end
   end

   function automatic logic [N-1:0] mValid();
      logic [N-1:0] v;
      v = '0;
      foreach (mPos[j]) v[mPos[j]] = 1'b1;
      return v;
   endfunction

   function automatic logic mReady();
      return !rst && (mMode == M_IDLE || mMode == M_RUN) &&
             (mPos.size() < N || bus.out_ready);
   endfunction

   function automatic logic mOutValid();
      return (mPos.size() > 0) && (mPos[0] == N - 1);
   endfunction

   function automatic logic mBusy();
      return (mPos.size() > 0) || (mMode != M_IDLE);
   endfunction

   // Advance the model by one clock using the inputs present now, then let
   // the clock edge happen and settle just after it.
   task automatic tick();
      int   limit;
      int   np;
      int   oldSize;
      logic fire;
      oldSize = mPos.size();
      if (rst) begin
         mData.delete();
         mPos.delete();
         mMode  = M_IDLE;
         mCount = 0;
      end else begin
         fire  = bus.in_valid && mReady();
         limit = N - 1;
         if (oldSize > 0 && mPos[0] == N - 1 && bus.out_ready) begin
            expQ.push_back(mData.pop_front());
            void'(mPos.pop_front());
            mCount++;
         end
         for (int j = 0; j < mPos.size(); j++) begin
            np      = (mPos[j] + 1 <= limit) ? mPos[j] + 1 : mPos[j];
            mPos[j] = np;
            limit   = np - 1;
         end
         if (fire) begin
            mData.push_back(inData);
            mPos.push_back(0);
         end
         case (mMode)
            M_IDLE:  if (bus.key_req) mMode = M_DRAIN; else if (fire) mMode = M_RUN;
            M_RUN:   if (bus.key_req) mMode = M_DRAIN; else if (mPos.size() == 0) mMode = M_IDLE;
            M_DRAIN: if (oldSize == 0) mMode = M_KEY;
            default: mMode = M_IDLE;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic ordy, input logic kreq);
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      bus.key_req   = kreq;
      inData        = {$urandom, $urandom, $urandom, $urandom};
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         drive(1'b1, 1'b1, 1'b0);
         compared++;
         if (bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset.in_ready c=%0d got %b exp 0", c, bus.in_ready);
         end
         compared++;
         if (bus.stage_en !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset.stage_en c=%0d got %b exp 0", c, bus.stage_en);
         end
         tick();
      end
      compared++;
      if (bus.stage_valid !== '0 || bus.blk_count !== '0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset.state got v=%b cnt=%0d busy=%b exp v=0 cnt=0 busy=0",
                  bus.stage_valid, bus.blk_count, bus.busy);
      end
      rst = 1'b0;
   endtask

   task automatic test_latency();
      for (int c = 0; c < 14; c++) begin
         drive(c == 0, 1'b1, 1'b0);
         compared++;
         if (bus.out_valid !== (c == N)) begin
            mismatched++;
            $display("[TB] FAIL latency.out_valid c=%0d got %b exp %b", c, bus.out_valid, c == N);
         end
         if (c == 5) begin
            compared++;
            if (bus.busy !== 1'b1 || bus.occupancy !== 1) begin
               mismatched++;
               $display("[TB] FAIL latency.busy got busy=%b occ=%0d exp 1/1", bus.busy, bus.occupancy);
            end
         end
         tick();
      end
      compared++;
      if (bus.blk_count !== 16'd1) begin
         mismatched++;
         $display("[TB] FAIL latency.blk_count got %0d exp 1", bus.blk_count);
      end
   endtask

   task automatic test_back_to_back();
      int first;
      int last;
      int fires;
      int base;
      first = -1;
      last  = -1;
      fires = 0;
      base  = mCount;
      obsQ.delete();
      expQ.delete();
      for (int c = 0; c < 34; c++) begin
         drive(c < 20, 1'b1, 1'b0);
         if (c < 20) begin
            compared++;
            if (bus.in_ready !== 1'b1) begin
               mismatched++;
               $display("[TB] FAIL b2b.in_ready c=%0d got %b exp 1", c, bus.in_ready);
            end
         end
         compared++;
         if (bus.stage_valid !== mValid()) begin
            mismatched++;
            $display("[TB] FAIL b2b.stage_valid c=%0d got %b exp %b", c, bus.stage_valid, mValid());
         end
         if (bus.out_valid === 1'b1) begin
            if (first < 0) first = c;
            last = c;
            fires++;
         end
         tick();
      end
      compared++;
      if (first != N || last != N + 19 || fires != 20) begin
         mismatched++;
         $display("[TB] FAIL b2b.out_window got first=%0d last=%0d n=%0d exp %0d/%0d/20",
                  first, last, fires, N, N + 19);
      end
      compared++;
      if (obsQ.size() != 20 || expQ.size() != 20) begin
         mismatched++;
         $display("[TB] FAIL b2b.count got obs=%0d model=%0d exp 20", obsQ.size(), expQ.size());
      end
      foreach (obsQ[k]) begin
         if (k < expQ.size()) begin
            compared++;
            if (obsQ[k] !== expQ[k]) begin
               mismatched++;
               $display("[TB] FAIL b2b.data k=%0d got %h exp %h", k, obsQ[k], expQ[k]);
            end
         end
      end
      compared++;
      if (bus.blk_count !== 16'(base + 20)) begin
         mismatched++;
         $display("[TB] FAIL b2b.blk_count got %0d exp %0d", bus.blk_count, base + 20);
      end
   endtask

   task automatic test_backpressure();
      int accepts;
      accepts = 0;
      obsQ.delete();
      expQ.delete();
      for (int c = 0; c < 15; c++) begin
         drive(1'b1, 1'b0, 1'b0);
         compared++;
         if (bus.in_ready !== (accepts < N)) begin
            mismatched++;
            $display("[TB] FAIL bp.in_ready c=%0d got %b exp %b", c, bus.in_ready, accepts < N);
         end
         if (bus.in_ready === 1'b1) accepts++;
         tick();
      end
      drive(1'b0, 1'b0, 1'b0);
      compared++;
      if (bus.occupancy !== N || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bp.full got occ=%0d ov=%b ir=%b exp %0d/1/0",
                  bus.occupancy, bus.out_valid, bus.in_ready, N);
      end
      for (int c = 0; c < 14; c++) begin
         drive(1'b0, 1'b1, 1'b0);
         compared++;
         if (bus.stage_valid !== mValid() || bus.out_valid !== mOutValid()) begin
            mismatched++;
            $display("[TB] FAIL bp.drain c=%0d got v=%b exp v=%b", c, bus.stage_valid, mValid());
         end
         tick();
      end
      compared++;
      if (obsQ.size() != N || expQ.size() != N) begin
         mismatched++;
         $display("[TB] FAIL bp.count got obs=%0d model=%0d exp %0d", obsQ.size(), expQ.size(), N);
      end
      foreach (obsQ[k]) begin
         if (k < expQ.size()) begin
            compared++;
            if (obsQ[k] !== expQ[k]) begin
               mismatched++;
               $display("[TB] FAIL bp.data k=%0d got %h exp %h", k, obsQ[k], expQ[k]);
            end
         end
      end
   endtask

   task automatic test_key_reload();
      int   emptyAt;
      int   loadAt;
      int   pulses;
      logic kreq;
      emptyAt = -1;
      loadAt  = -1;
      pulses  = 0;
      kreq    = 1'b0;
      for (int c = 0; c < 22; c++) begin
         if (c == 3) kreq = 1'b1;
         if (loadAt >= 0) kreq = 1'b0;
         drive(c != 3 && c < 20, 1'b1, kreq);
         if (c == 4) begin
            compared++;
            if (bus.in_ready !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL key.in_ready_drop got %b exp 0", bus.in_ready);
            end
         end
         if (c > 3 && emptyAt < 0 && bus.stage_valid === '0) emptyAt = c;
         compared++;
         if (bus.key_load !== (mMode == M_KEY) || bus.busy !== mBusy()) begin
            mismatched++;
            $display("[TB] FAIL key.model c=%0d got kl=%b busy=%b exp %b/%b",
                     c, bus.key_load, bus.busy, mMode == M_KEY, mBusy());
         end
         if (bus.key_load === 1'b1) begin
            pulses++;
            if (loadAt < 0) loadAt = c;
         end
         if (loadAt >= 0 && c == loadAt + 1) begin
            compared++;
            if (bus.in_ready !== 1'b1) begin
               mismatched++;
               $display("[TB] FAIL key.resume got %b exp 1", bus.in_ready);
            end
         end
         tick();
      end
      compared++;
      if (pulses != 1 || emptyAt != 13 || loadAt != emptyAt + 1) begin
         mismatched++;
         $display("[TB] FAIL key.timing got pulses=%0d empty=%0d load=%0d exp 1/13/14",
                  pulses, emptyAt, loadAt);
      end
      for (int c = 0; c < 14; c++) begin
         drive(1'b0, 1'b1, 1'b0);
         tick();
      end
   endtask

   task automatic test_reset_midop();
      obsQ.delete();
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, 1'b1, 1'b0);
         tick();
      end
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0);
      compared++;
      if (bus.in_ready !== 1'b0 || bus.stage_en !== '0) begin
         mismatched++;
         $display("[TB] FAIL midrst.gate got ir=%b en=%b exp 0/0", bus.in_ready, bus.stage_en);
      end
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b0);
      compared++;
      if (bus.stage_valid !== '0 || bus.out_valid !== 1'b0 || bus.blk_count !== '0) begin
         mismatched++;
         $display("[TB] FAIL midrst.clear got v=%b ov=%b cnt=%0d exp 0/0/0",
                  bus.stage_valid, bus.out_valid, bus.blk_count);
      end
      for (int c = 0; c < 12; c++) begin
         drive(1'b0, 1'b1, 1'b0);
         compared++;
         if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midrst.stale c=%0d got %b exp 0", c, bus.out_valid);
         end
         tick();
      end
      compared++;
      if (obsQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL midrst.outputs got %0d exp 0", obsQ.size());
      end
   endtask

   task automatic test_wrap();
      for (int c = 0; c < 30; c++) begin
         drive(c < 17, 1'b1, 1'b0);
         tick();
      end
      compared++;
      if (wbus.blk_count !== 4'd1 || bus.blk_count !== 16'd17) begin
         mismatched++;
         $display("[TB] FAIL wrap.blk_count got w=%0d m=%0d exp 1/17", wbus.blk_count, bus.blk_count);
      end
   endtask

   task automatic test_random();
      logic kreq;
      logic sawLoad;
      kreq    = 1'b0;
      sawLoad = 1'b0;
      obsQ.delete();
      expQ.delete();
      for (int c = 0; c < 400; c++) begin
         if (sawLoad) kreq = 1'b0;
         else if (!kreq && $urandom_range(0, 39) == 0) kreq = 1'b1;
         drive(c < 380 && $urandom_range(0, 3) != 0,
               c >= 380 || $urandom_range(0, 2) != 0, kreq);
         compared++;
         if (bus.in_ready !== mReady() || bus.out_valid !== mOutValid() ||
             bus.stage_valid !== mValid() || bus.occupancy !== mPos.size() ||
             bus.busy !== mBusy() || bus.key_load !== (mMode == M_KEY) ||
             bus.blk_count !== 16'(mCount) || wbus.blk_count !== 4'(mCount)) begin
            mismatched++;
            $display("[TB] FAIL rnd.cycle c=%0d got ir=%b ov=%b v=%b occ=%0d busy=%b kl=%b cnt=%0d exp ir=%b ov=%b v=%b occ=%0d busy=%b kl=%b cnt=%0d",
                     c, bus.in_ready, bus.out_valid, bus.stage_valid, bus.occupancy, bus.busy,
                     bus.key_load, bus.blk_count, mReady(), mOutValid(), mValid(), mPos.size(),
                     mBusy(), mMode == M_KEY, mCount);
         end
         sawLoad = bus.key_load;
         tick();
      end
      compared++;
      if (obsQ.size() != expQ.size()) begin
         mismatched++;
         $display("[TB] FAIL rnd.count got %0d exp %0d", obsQ.size(), expQ.size());
      end
      foreach (obsQ[k]) begin
         if (k < expQ.size()) begin
            compared++;
            if (obsQ[k] !== expQ[k]) begin
               mismatched++;
               $display("[TB] FAIL rnd.data k=%0d got %h exp %h", k, obsQ[k], expQ[k]);
            end
         end
      end
   endtask

   initial begin
      mMode         = M_IDLE;
      mCount        = 0;
      rst           = 1'b1;
      inData        = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.key_req   = 1'b0;
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_key_reload();
      test_reset_midop();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
